// File: rtl/vga_capture_pkg.sv
// Shared constants for the VGA capture path.
// Holds the default frame geometry, the 640x480 timing constants shared with
// vga_ctrl, the capture FSM state encodings and the pixel payload struct.
package vga_capture_pkg;

    // Default geometry; vga_capture exposes these as overridable parameters.
    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned X_W_DEF      = 10;
    localparam int unsigned Y_AW_DEF     = 9;
    localparam int unsigned DATA_W_DEF   = 24;

    // 640x480@60 blanking, as generated by vga_ctrl.
    localparam int unsigned H_FRONT = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BACK  = 48;
    localparam int unsigned V_FRONT = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BACK  = 33;

    // Capture FSM encodings.
    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    // Pixel payload as carried on the VGA bus.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_capture_sync_edge.sv
// Two-flop input register with edge detection.
// Ports: clk, reset (async, active-low), d (raw input);
//        s1 (registered d), prev (s1 one cycle later),
//        rise_c / fall_c (combinational edges between prev and s1).
module vga_capture_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s1,
    output logic prev,
    output logic rise_c,
    output logic fall_c
);

    // Stage 1 samples the pin, stage 2 keeps the previous sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d;
            prev <= s1;
        end
    end

    assign rise_c = ~prev & s1;
    assign fall_c = prev & ~s1;

endmodule

// File: rtl/vga_capture.sv
// VGA sink: recovers pixel coordinates from the vga_ctrl stream, locks onto
// the frame timing and writes active pixels to a framebuffer.
// Ports: clk, reset (async, active-low); hsync, vsync, valid, vga_r/g/b in;
//        wr_en, wr_addr = {x, y[Y_AW-1:0]}, wr_data = {r,g,b} write port;
//        locked, frame_done (pulse), err (pulse), frame_cnt (good frames).
module vga_capture
    import vga_capture_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned X_W      = X_W_DEF,
    parameter int unsigned Y_AW     = Y_AW_DEF,
    parameter int unsigned DATA_W   = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  valid,
    input  logic [7:0]            vga_r,
    input  logic [7:0]            vga_g,
    input  logic [7:0]            vga_b,
    output logic                  wr_en,
    output logic [X_W+Y_AW-1:0]   wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  locked,
    output logic                  frame_done,
    output logic                  err,
    output logic [15:0]           frame_cnt
);

    // One extra bit so an over-long frame (V_ACTIVE+1 lines) stays distinct.
    localparam int unsigned Y_W = Y_AW + 1;

    logic           vsync_s1, vsync_prev, vfall, vsync_rise_unused;
    logic           valid_s1, valid_prev, vfall_valid, vrise_valid_unused;
    logic           hsync_s1, unused_hsync;
    rgb_t           rgb_s1;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y, y_inc, y_line;
    logic           pix, line_end, line_ok, frame_ok, in_window;
    logic [1:0]     state, next_state;
    logic           do_err, do_done, do_write;

    vga_capture_sync_edge u_vsync (
        .clk    (clk),
        .reset  (reset),
        .d      (vsync),
        .s1     (vsync_s1),
        .prev   (vsync_prev),
        .rise_c (vsync_rise_unused),
        .fall_c (vfall)
    );

    vga_capture_sync_edge u_valid (
        .clk    (clk),
        .reset  (reset),
        .d      (valid),
        .s1     (valid_s1),
        .prev   (valid_prev),
        .rise_c (vrise_valid_unused),
        .fall_c (vfall_valid)
    );

    // Stage 1 for the remaining inputs; line boundaries come from valid, so
    // hsync is sampled but not used.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_s1 <= 1'b0;
            rgb_s1   <= '0;
        end else begin
            hsync_s1 <= hsync;
            rgb_s1   <= '{r: vga_r, g: vga_g, b: vga_b};
        end
    end
    assign unused_hsync = hsync_s1;

    // Pixels count only outside the vsync pulse; a line end is still honoured
    // in the cycle vsync falls so the last line is counted before the frame check.
    always_comb begin
        pix       = valid_s1 & vsync_s1;
        line_end  = vfall_valid & vsync_prev;
        line_ok   = (x == X_W'(H_ACTIVE));
        y_inc     = (y == '1) ? y : y + Y_W'(1);
        y_line    = line_end ? y_inc : y;
        frame_ok  = (y_line == Y_W'(V_ACTIVE));
        in_window = (x < X_W'(H_ACTIVE)) && (y < Y_W'(V_ACTIVE));
    end

    // Coordinate counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x <= '0;
            y <= '0;
        end else if (vfall) begin
            x <= '0;
            y <= '0;
        end else if (line_end) begin
            x <= '0;
            y <= y_inc;
        end else if (pix && (x != '1)) begin
            x <= x + X_W'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_SEEK;
        end else begin
            state <= next_state;
        end
    end

    // Next state. A bad line that coincides with vfall drops to SEEK and the
    // same vfall immediately restarts acquisition.
    always_comb begin
        next_state = state;
        do_err     = 1'b0;
        do_done    = 1'b0;
        case (state)
            ST_SEEK: begin
                if (vfall) next_state = ST_ACQ;
            end
            ST_ACQ: begin
                if (line_end && !line_ok) next_state = vfall ? ST_ACQ : ST_SEEK;
                else if (vfall && frame_ok) next_state = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (line_end && !line_ok) begin
                    do_err     = 1'b1;
                    next_state = vfall ? ST_ACQ : ST_SEEK;
                end else if (vfall) begin
                    if (frame_ok) begin
                        do_done = 1'b1;
                    end else begin
                        do_err     = 1'b1;
                        next_state = ST_ACQ;
                    end
                end
            end
            default: next_state = ST_SEEK;
        endcase
        do_write = (state == ST_LOCKED) && pix && in_window;
    end

    // Registered outputs and framebuffer write stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked     <= 1'b0;
            err        <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            locked     <= (next_state == ST_LOCKED);
            err        <= do_err;
            frame_done <= do_done;
            wr_en      <= do_write;
            if (do_done) frame_cnt <= frame_cnt + 16'd1;
            if (do_write) begin
                wr_addr <= {x, y[Y_AW-1:0]};
                wr_data <= DATA_W'(rgb_s1);
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a reduced 16x6 frame: random pixel data and frame
// shapes; a frame-level lock model predicts writes and events, and a monitor
// compares them as the DUT produces them.
module tb_vga_capture;

    localparam int unsigned H  = 16;
    localparam int unsigned V  = 6;
    localparam int unsigned HB = 4;

    logic        clk = 1'b0;
    logic        reset, hsync, vsync, valid;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        wr_en, locked, frame_done, err;
    logic [18:0] wr_addr;
    logic [23:0] wr_data;
    logic [15:0] frame_cnt;

    vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(10), .Y_AW(9), .DATA_W(24)) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .locked(locked),
        .frame_done(frame_done), .err(err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [18:0] addr;
        logic [23:0] data;
        logic [31:0] due;
    } wr_exp_t;
    typedef struct packed {
        logic        is_done;
        logic [15:0] cnt;
    } ev_t;
    typedef enum {M_SEEK, M_ACQ, M_LOCKED} mstate_t;

    wr_exp_t wq[$];
    ev_t     eq[$];
    mstate_t mstate = M_SEEK;
    int      lines  = 0;
    int      fcnt   = 0;
    int      n_cmp  = 0;
    int      n_bad  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            valid = 1'b0;
            tick();
        end
    endtask

    // Model: what a completed line means at frame level.
    task automatic model_line_end(input int len);
        if (mstate != M_SEEK) begin
            if (len != int'(H)) begin
                if (mstate == M_LOCKED) eq.push_back('{is_done: 1'b0, cnt: 16'(fcnt)});
                mstate = M_SEEK;
            end
            lines++;
        end
    endtask

    // Model: frame boundary at the vsync fall.
    task automatic model_vfall();
        case (mstate)
            M_SEEK: mstate = M_ACQ;
            M_ACQ:  if (lines == int'(V)) mstate = M_LOCKED;
            default: begin
                if (lines == int'(V)) begin
                    fcnt = (fcnt + 1) % 65536;
                    eq.push_back('{is_done: 1'b1, cnt: 16'(fcnt)});
                end else begin
                    eq.push_back('{is_done: 1'b0, cnt: 16'(fcnt)});
                    mstate = M_ACQ;
                end
            end
        endcase
        lines = 0;
    endtask

    task automatic send_line(input int len, input bit skip_blank);
        logic [23:0] d;
        for (int i = 0; i < len; i++) begin
            d = 24'($urandom);
            {vga_r, vga_g, vga_b} = d;
            valid = 1'b1;
            hsync = 1'b1;
            if (mstate == M_LOCKED && i < int'(H) && lines < int'(V))
                wq.push_back('{addr: {10'(i), 9'(lines)}, data: d, due: cyc + 2});
            tick();
        end
        valid = 1'b0;
        model_line_end(len);
        if (!skip_blank) begin
            hsync = 1'b0;
            idle(2);
            hsync = 1'b1;
            idle(int'(HB) - 2);
        end
    endtask

    // vsync pulse; locked must hold for one cycle and settle on the second.
    task automatic send_vsync();
        logic was_locked;
        was_locked = (mstate == M_LOCKED);
        valid = 1'b0;
        vsync = 1'b0;
        model_vfall();
        tick();
        check("locked_before_vfall", locked, was_locked);
        tick();
        check("locked_after_vfall", locked, mstate == M_LOCKED);
        idle(6);
        vsync = 1'b1;
        idle(6);
    endtask

    task automatic send_frame(input int nlines, input int bad_idx, input int bad_len, input bit simul);
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_idx) ? bad_len : int'(H), simul && (l == nlines - 1));
        if (!simul) idle(int'(H));
        send_vsync();
    endtask

    // Monitor: pops expectations whenever the DUT presents a write or event.
    initial begin
        wr_exp_t e;
        ev_t     ev;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (wr_en) begin
                    if (wq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
                    end else begin
                        e = wq.pop_front();
                        check("wr_addr", wr_addr, e.addr);
                        check("wr_data", wr_data, e.data);
                        check("wr_latency", cyc, e.due);
                    end
                end
                if (err || frame_done) begin
                    check("err_done_exclusive", err & frame_done, 0);
                    if (eq.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_event: got err=%0b frame_done=%0b, expected none", err, frame_done);
                    end else begin
                        ev = eq.pop_front();
                        check("event_kind", frame_done, ev.is_done);
                        check("locked_at_event", locked, ev.is_done);
                        if (frame_done) check("frame_cnt", frame_cnt, ev.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int nl, bi, bl;
        reset = 1'b0; hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
        vga_r = 8'h0; vga_g = 8'h0; vga_b = 8'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_locked", locked, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_err", err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        reset = 1'b1;
        idle(4);

        // valid stuck high while vsync toggles, from SEEK: nothing written or flagged
        valid = 1'b1;
        repeat (3) begin
            vsync = 1'b0;
            repeat (3) begin {vga_r, vga_g, vga_b} = 24'($urandom); tick(); end
            vsync = 1'b1;
            repeat (30) begin {vga_r, vga_g, vga_b} = 24'($urandom); tick(); end
        end
        idle(10);
        check("stuck_valid_locked", locked, 0);

        // Three clean frames: ignored, acquired, written
        repeat (3) send_frame(int'(V), -1, 0, 1'b0);
        check("frame_cnt_after3", frame_cnt, 16'(fcnt));

        // Short line while locked, then relock
        send_frame(int'(V), 2, int'(H) - 1, 1'b0);
        repeat (3) send_frame(int'(V), -1, 0, 1'b0);

        // One line too many, then relock
        send_frame(int'(V) + 1, -1, 0, 1'b0);
        send_frame(int'(V), -1, 0, 1'b1);
        send_frame(int'(V), -1, 0, 1'b0);

        // Over-long line while locked
        send_frame(int'(V), 1, int'(H) + 2, 1'b0);
        repeat (2) send_frame(int'(V), -1, 0, 1'b0);

        // Random frame shapes
        repeat (18) begin
            case ($urandom_range(0, 4))
                0: nl = int'(V) - 1;
                1: nl = int'(V) + 1;
                default: nl = int'(V);
            endcase
            bi = -1;
            bl = 0;
            if ($urandom_range(0, 3) == 0) begin
                bi = int'($urandom_range(0, nl - 1));
                bl = int'($urandom_range(1, H + 3));
                if (bl == int'(H)) bl = int'(H) - 1;
            end
            send_frame(nl, bi, bl, 1'($urandom_range(0, 1)));
        end

        // Make sure we are locked, then reset mid-line
        repeat (2) send_frame(int'(V), -1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [23:0] d;
            d = 24'($urandom);
            {vga_r, vga_g, vga_b} = d;
            valid = 1'b1;
            if (mstate == M_LOCKED)
                wq.push_back('{addr: {10'(i), 9'(0)}, data: d, due: cyc + 2});
            tick();
        end
        check("pre_reset_locked", locked, mstate == M_LOCKED);
        #2;
        reset = 1'b0;
        wq.delete();
        eq.delete();
        mstate = M_SEEK;
        lines  = 0;
        fcnt   = 0;
        valid  = 1'b0;
        #1;
        check("async_rst_wr_en", wr_en, 0);
        check("async_rst_locked", locked, 0);
        check("async_rst_err", err, 0);
        check("async_rst_frame_done", frame_done, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        idle(int'(H));
        send_vsync();
        repeat (2) send_frame(int'(V), -1, 0, 1'b0);
        check("frame_cnt_after_reset", frame_cnt, 16'(fcnt));

        idle(10);
        check("writes_outstanding", wq.size(), 0);
        check("events_outstanding", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
